// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern generator.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [5:0] PATTERN_DEF = 6'b101011;
  localparam int         REP_W       = 4;
  localparam int         GAP_W       = 3;

endpackage

// File: rtl/seq_piso.sv
// Parallel-load, shift-left register; serial output is the MSB.
module seq_piso #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             r,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             ser
);

  logic [WIDTH-1:0] q;

  // Load has priority over shift so a frame reload can coincide with the last shift.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign ser = q[WIDTH-1];

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: sends PATTERN MSB first, rep times, with gap
// idle-zero bits between frames, and reports busy/done/frame_cnt.
module seq_gen
  import seq_pkg::*;
#(
  parameter int               WIDTH   = 6,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(PATTERN_DEF)
) (
  input  logic             clk,
  input  logic             r,
  input  logic             start,
  input  logic [REP_W-1:0] rep,
  input  logic [GAP_W-1:0] gap,
  output logic             d,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] frame_cnt
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [REP_W-1:0] rep_l;
  logic [GAP_W-1:0] gap_l;
  logic [REP_W-1:0] fc_next;
  logic             last_bit;
  logic             final_frame;
  logic             load;
  logic             shift;
  logic             ser;

  assign fc_next     = frame_cnt + REP_W'(1);
  assign last_bit    = (bit_cnt == '0);
  assign final_frame = (fc_next >= rep_l);

  // Shift-register control: load on accept and on every frame restart, shift while sending.
  always_comb begin
    load  = 1'b0;
    shift = 1'b0;
    case (state)
      IDLE: load = start;
      SEND: begin
        shift = 1'b1;
        if (last_bit && !final_frame && (gap_l == '0)) begin
          load = 1'b1;
        end
      end
      GAP:     load = (gap_cnt <= GAP_W'(1));
      default: ;
    endcase
  end

  seq_piso #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk   (clk),
    .r     (r),
    .load  (load),
    .shift (shift),
    .din   (PATTERN),
    .ser   (ser)
  );

  // Burst FSM with counters and registered serial/handshake outputs.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state     <= IDLE;
      d         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      rep_l     <= '0;
      gap_l     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          d    <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            rep_l     <= (rep == '0) ? REP_W'(1) : rep;
            gap_l     <= gap;
            frame_cnt <= '0;
            bit_cnt   <= CW'(WIDTH - 1);
            state     <= SEND;
          end
        end
        SEND: begin
          d    <= ser;
          busy <= 1'b1;
          if (last_bit) begin
            frame_cnt <= fc_next;
            bit_cnt   <= CW'(WIDTH - 1);
            if (final_frame) begin
              state <= DONE;
            end else if (gap_l != '0) begin
              gap_cnt <= gap_l;
              state   <= GAP;
            end
          end else begin
            bit_cnt <= bit_cnt - CW'(1);
          end
        end
        GAP: begin
          d    <= 1'b0;
          busy <= 1'b1;
          if (gap_cnt <= GAP_W'(1)) begin
            state <= SEND;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        DONE: begin
          d     <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: stimulus pushes expected output cycles,
// a negedge monitor pops and compares whenever busy or done is high.
module tb_seq_gen;

  typedef struct {
    logic       d;
    logic       busy;
    logic       done;
    logic [3:0] fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       r   = 1'b1;
  logic       start = 1'b0;
  logic [3:0] rep = '0;
  logic [2:0] gap = '0;
  logic       d, busy, done;
  logic [3:0] frame_cnt;

  logic [5:0] pat = 6'b101011;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   done_cnt    = 0;
  int   done_cyc    = -100;
  int   rise_cyc    = -100;
  int   turn        = 0;
  logic prev_busy   = 1'b0;

  seq_gen #(
    .WIDTH   (6),
    .PATTERN (6'b101011)
  ) dut (
    .clk       (clk),
    .r         (r),
    .start     (start),
    .rep       (rep),
    .gap       (gap),
    .d         (d),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  always @(negedge clk) begin
    exp_t e;
    if (!r) begin
      if (busy && !prev_busy) begin
        rise_cyc = cyc;
        turn     = cyc - done_cyc;
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (busy || done) begin
        vectors = vectors + 1;
        if (q.size() == 0) begin
          miscompares = miscompares + 1;
          $display("FAIL unexpected_output cyc=%0d: got d=%b busy=%b done=%b fc=%0d, none expected",
                   cyc, d, busy, done, frame_cnt);
        end else begin
          e = q.pop_front();
          if (d !== e.d || busy !== e.busy || done !== e.done || frame_cnt !== e.fc) begin
            miscompares = miscompares + 1;
            $display("FAIL stream cyc=%0d: got d=%b busy=%b done=%b fc=%0d, expected d=%b busy=%b done=%b fc=%0d",
                     cyc, d, busy, done, frame_cnt, e.d, e.busy, e.done, e.fc);
          end
        end
      end
      prev_busy = busy;
    end else begin
      prev_busy = 1'b0;
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    vectors = vectors + 1;
    if (act != expv) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic push_burst(input int rp, input int gp);
    int   n;
    exp_t e;
    n = (rp == 0) ? 1 : rp;
    for (int f = 0; f < n; f++) begin
      for (int i = 0; i < 6; i++) begin
        e.d    = pat[5-i];
        e.busy = 1'b1;
        e.done = 1'b0;
        e.fc   = 4'((i == 5) ? f + 1 : f);
        q.push_back(e);
      end
      if (f < n - 1) begin
        for (int j = 0; j < gp; j++) begin
          e.d    = 1'b0;
          e.busy = 1'b1;
          e.done = 1'b0;
          e.fc   = 4'(f + 1);
          q.push_back(e);
        end
      end
    end
    e.d    = 1'b0;
    e.busy = 1'b0;
    e.done = 1'b1;
    e.fc   = 4'(n);
    q.push_back(e);
  endtask

  task automatic wait_done(input int tgt, input int budget, input string nm);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt >= tgt) break;
    end
    if (k >= budget) begin
      vectors     = vectors + 1;
      miscompares = miscompares + 1;
      $display("FAIL %s_timeout: got %0d done pulses expected %0d", nm, done_cnt, tgt);
    end
  endtask

  // One burst; optionally pulses start with other settings mid-frame.
  task automatic run_burst(input int rp, input int gp, input bit poke, input string nm);
    int tgt;
    int acc;
    tgt = done_cnt + 1;
    @(negedge clk);
    start = 1'b1;
    rep   = 4'(rp);
    gap   = 3'(gp);
    push_burst(rp, gp);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rep   = 4'd9;
    gap   = 3'd6;
    acc   = cyc;
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      rep   = 4'd5;
      gap   = 3'd7;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(tgt, 400, nm);
    chk({nm, "_latency"}, rise_cyc, acc + 1);
    chk({nm, "_drained"}, q.size(), 0);
    chk({nm, "_frame_cnt_hold"}, int'(frame_cnt), (rp == 0) ? 1 : rp);
  endtask

  initial begin
    int tgt;
    int dc;

    rep = '0;
    gap = '0;
    #2;
    chk("reset_d", int'(d), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_fc", int'(frame_cnt), 0);
    repeat (2) @(negedge clk);
    r = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    run_burst(1, 0, 1'b0, "single");
    run_burst(3, 2, 1'b0, "rep3_gap2");
    run_burst(2, 0, 1'b0, "b2b");
    chk("b2b_done_after_rise", done_cyc - rise_cyc, 12);
    run_burst(0, 3, 1'b0, "rep0");
    run_burst(2, 1, 1'b1, "ignored_start");
    run_burst(2, 7, 1'b0, "gap7");
    run_burst(15, 0, 1'b0, "rep15");

    // Held start: two back-to-back bursts, start dropped after the second accept.
    tgt = done_cnt + 2;
    @(negedge clk);
    start = 1'b1;
    rep   = 4'd1;
    gap   = 3'd0;
    push_burst(1, 0);
    push_burst(1, 0);
    @(posedge clk);
    repeat (8) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(tgt, 100, "held");
    chk("held_turnaround", turn, 2);
    chk("held_drained", q.size(), 0);
    chk("held_fc", int'(frame_cnt), 1);

    // Reset in the middle of the second frame of a rep=3 burst.
    dc = done_cnt;
    @(negedge clk);
    start = 1'b1;
    rep   = 4'd3;
    gap   = 3'd1;
    push_burst(3, 1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    chk("pre_reset_fc", int'(frame_cnt), 1);
    r = 1'b1;
    #1;
    chk("midreset_d", int'(d), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_done", int'(done), 0);
    chk("midreset_fc", int'(frame_cnt), 0);
    q.delete();
    repeat (2) @(negedge clk);
    r = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_no_done", done_cnt, dc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
